// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time. The row returns
//   are synchronised and debounced, and the pressed key is encoded as
//   {row[1:0], col[1:0]}. The first pressed key that is found locks the scan
//   onto its column until that key is released.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_out    out  [3:0] column drive, exactly one bit low
//   key_val    out  [3:0] code of the last accepted key
//   key_down   out  high while an accepted key is held
//   key_strobe out  one-cycle pulse per accepted press (and per repeat)
//
// Configuration
//   KEYPAD_TYPEMATIC_EN : when defined, a held key repeats its strobe every
//                         REPEAT_SAMPLES sample ticks. When undefined, each
//                         accepted press gives exactly one strobe.

module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_CNT   = 4'd4,
  parameter logic [7:0]  REPEAT_SAMPLES = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_val,
  output logic       key_down,
  output logic       key_strobe
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync1_q, rs_q;
  logic [15:0] div_q, div_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  rel_q, rel_d;
  logic [3:0]  key_val_q, key_val_d;
  logic        key_down_q, key_down_d;
  logic        key_strobe_q, key_strobe_d;
`ifdef KEYPAD_TYPEMATIC_EN
  logic [7:0]  rep_q, rep_d;
`else
  logic        unused_rep;
  assign unused_rep = ^REPEAT_SAMPLES;
`endif

  logic       tick;
  logic       key_present;
  logic [1:0] row_code;

  // The dwell counter free-runs in every state; its last count is the tick.
  assign tick        = (div_q == (SCAN_DIV - 16'd1));
  assign div_d       = tick ? 16'd0 : (div_q + 16'd1);
  assign key_present = (rs_q != 4'hF);

  // Lowest-index low row wins when several rows are pulled low together.
  always_comb begin
    row_code = 2'd3;
    if (!rs_q[0])      row_code = 2'd0;
    else if (!rs_q[1]) row_code = 2'd1;
    else if (!rs_q[2]) row_code = 2'd2;
  end

  // Scan / debounce / hold sequencing. Everything advances only on ticks,
  // so the synchroniser has settled after each column change.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cand_d       = cand_q;
    match_d      = match_q;
    rel_d        = rel_q;
    key_val_d    = key_val_q;
    key_down_d   = key_down_q;
    key_strobe_d = 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
    rep_d        = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!key_present) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_d  = {row_code, col_q};
            match_d = 4'd1;
            rel_d   = 4'd0;
            if (DEBOUNCE_CNT == 4'd1) begin
              // A single consistent sample is enough: accept immediately.
              state_d      = HELD;
              key_val_d    = {row_code, col_q};
              key_down_d   = 1'b1;
              key_strobe_d = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
              rep_d        = 8'd0;
`endif
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (key_present && (row_code == cand_q[3:2])) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == DEBOUNCE_CNT) begin
              state_d      = HELD;
              key_val_d    = cand_q;
              key_down_d   = 1'b1;
              key_strobe_d = 1'b1;
              rel_d        = 4'd0;
`ifdef KEYPAD_TYPEMATIC_EN
              rep_d        = 8'd0;
`endif
            end
          end else begin
            // Bounce or a different row: give up and move on.
            match_d = 4'd0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (key_present) begin
            rel_d = 4'd0;
          end else begin
            rel_d = rel_q + 4'd1;
          end
          if (!key_present && ((rel_q + 4'd1) == DEBOUNCE_CNT)) begin
            // Release wins over a repeat that would fall on the same tick.
            state_d    = SCAN;
            key_down_d = 1'b0;
            col_d      = col_q + 2'd1;
            rel_d      = 4'd0;
            match_d    = 4'd0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_d      = 8'd0;
`endif
          end else begin
`ifdef KEYPAD_TYPEMATIC_EN
            rep_d = rep_q + 8'd1;
            if ((rep_q + 8'd1) == REPEAT_SAMPLES) begin
              rep_d        = 8'd0;
              key_strobe_d = 1'b1;
            end
`endif
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 4'hF;
      rs_q         <= 4'hF;
      state_q      <= SCAN;
      div_q        <= 16'd0;
      col_q        <= 2'd0;
      cand_q       <= 4'd0;
      match_q      <= 4'd0;
      rel_q        <= 4'd0;
      key_val_q    <= 4'd0;
      key_down_q   <= 1'b0;
      key_strobe_q <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_q        <= 8'd0;
`endif
    end else begin
      sync1_q      <= row_in;
      rs_q         <= sync1_q;
      state_q      <= state_d;
      div_q        <= div_d;
      col_q        <= col_d;
      cand_q       <= cand_d;
      match_q      <= match_d;
      rel_q        <= rel_d;
      key_val_q    <= key_val_d;
      key_down_q   <= key_down_d;
      key_strobe_q <= key_strobe_d;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign key_val    = key_val_q;
  assign key_down   = key_down_q;
  assign key_strobe = key_strobe_q;

endmodule
